// File: rtl/seq_divider_pkg.sv
// Shared definitions for the signed sequential divider: state encoding and default width.
package seq_divider_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/seq_divider_twos_mag.sv
// Conditional two's-complement negate: yields -val when neg is set, val otherwise.
module twos_mag
  import seq_divider_pkg::*;
#(
  parameter int W = DW_DEFAULT
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] mag
);

  // Negate on request; the same block serves absolute value and sign restore.
  always_comb begin
    mag = val;
    if (neg) begin
      mag = ~val + W'(1);
    end else begin
      mag = val;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Signed restoring divider: 2*DW-bit dividend by DW-bit divisor, one quotient bit per cycle,
// truncating toward zero with overflow and divide-by-zero reporting.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            ovf,
  output logic            dz
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
  localparam logic [DW-1:0] QMAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] QMAX_NEG = {1'b1, {(DW-1){1'b0}}};

  state_e          state_r, state_nxt_s;
  logic [2*DW-1:0] dvd_r;
  logic [DW-1:0]   dvs_r;
  logic [DW-1:0]   rem_r, quo_r;
  logic [DW:0]     bmag_r;
  logic            q_neg_r, r_neg_r;
  logic [CW-1:0]   cnt_r;
  logic            busy_r, done_r, ovf_r, dz_r;
  logic [DW-1:0]   quotient_r, remainder_r;

  logic [2*DW-1:0] amag_s;
  logic [DW:0]     bmag_s;
  logic            dz_s, big_s, range_s;
  logic [DW:0]     shifted_s;
  logic [DW-1:0]   rem_sub_s;
  logic [DW-1:0]   qfix_s, rfix_s;

  twos_mag #(.W(2*DW)) u_mag_dvd (.val(dvd_r), .neg(dvd_r[2*DW-1]), .mag(amag_s));
  twos_mag #(.W(DW+1)) u_mag_dvs (.val({dvs_r[DW-1], dvs_r}), .neg(dvs_r[DW-1]), .mag(bmag_s));
  twos_mag #(.W(DW))   u_fix_quo (.val(quo_r), .neg(q_neg_r), .mag(qfix_s));
  twos_mag #(.W(DW))   u_fix_rem (.val(rem_r), .neg(r_neg_r), .mag(rfix_s));

  assign dz_s      = (dvs_r == {DW{1'b0}});
  // A high half already >= divisor means the quotient cannot fit in DW bits.
  assign big_s     = ({1'b0, amag_s[2*DW-1:DW]} >= bmag_s);
  assign range_s   = q_neg_r ? (quo_r > QMAX_NEG) : (quo_r > QMAX_POS);
  assign shifted_s = {rem_r, quo_r[DW-1]};
  assign rem_sub_s = DW'(shifted_s - bmag_r);

  assign busy      = busy_r;
  assign done      = done_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign ovf       = ovf_r;
  assign dz        = dz_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go) state_nxt_s = ST_LOAD;
        else    state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (dz_s || big_s) state_nxt_s = ST_FIX;
        else               state_nxt_s = ST_DIV;
      end
      ST_DIV: begin
        if (cnt_r == CNT_LAST) state_nxt_s = ST_FIX;
        else                   state_nxt_s = ST_DIV;
      end
      ST_FIX:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath, iteration counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_r       <= {(2*DW){1'b0}};
      dvs_r       <= {DW{1'b0}};
      rem_r       <= {DW{1'b0}};
      quo_r       <= {DW{1'b0}};
      bmag_r      <= {(DW+1){1'b0}};
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ovf_r       <= 1'b0;
      dz_r        <= 1'b0;
      quotient_r  <= {DW{1'b0}};
      remainder_r <= {DW{1'b0}};
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (go) begin
            dvd_r <= dividend;
            dvs_r <= divisor;
            ovf_r <= 1'b0;
            dz_r  <= 1'b0;
          end
        end
        ST_LOAD: begin
          rem_r   <= amag_s[2*DW-1:DW];
          quo_r   <= amag_s[DW-1:0];
          bmag_r  <= bmag_s;
          q_neg_r <= dvd_r[2*DW-1] ^ dvs_r[DW-1];
          r_neg_r <= dvd_r[2*DW-1];
          cnt_r   <= {CW{1'b0}};
          if (dz_s) begin
            dz_r  <= 1'b1;
            ovf_r <= 1'b1;
          end else if (big_s) begin
            ovf_r <= 1'b1;
          end
        end
        ST_DIV: begin
          if (shifted_s >= bmag_r) begin
            rem_r <= rem_sub_s;
            quo_r <= {quo_r[DW-2:0], 1'b1};
          end else begin
            rem_r <= shifted_s[DW-1:0];
            quo_r <= {quo_r[DW-2:0], 1'b0};
          end
          cnt_r <= (cnt_r == CNT_LAST) ? {CW{1'b0}} : cnt_r + CW'(1);
        end
        ST_FIX: begin
          done_r <= 1'b1;
          if (ovf_r || range_s) begin
            ovf_r       <= 1'b1;
            quotient_r  <= {DW{1'b0}};
            remainder_r <= {DW{1'b0}};
          end else begin
            quotient_r  <= qfix_s;
            remainder_r <= rfix_s;
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner vectors plus randomized operations
// compared against an integer-arithmetic reference model.
module tb_seq_divider;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic [15:0]   dividend = 16'h0000;
  logic [7:0]    divisor = 8'h00;
  logic          busy, done, ovf, dz;
  logic [7:0]    quotient, remainder;

  int checks = 0;
  int failures = 0;

  seq_divider #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .go(go), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed integer division with the early overflow rule on the high half.
  function automatic void ref_div(input logic [15:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic o, output logic z, output int lat);
    int ai, bi, am, bm, qi, ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    am = (ai < 0) ? -ai : ai;
    bm = (bi < 0) ? -bi : bi;
    q = 8'h00; r = 8'h00; o = 1'b0; z = 1'b0; lat = 10;
    if (bi == 0) begin
      z = 1'b1; o = 1'b1; lat = 2;
    end else if ((am / 256) >= bm) begin
      o = 1'b1; lat = 2;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      if (qi > 127 || qi < -128) begin
        o = 1'b1;
      end else begin
        q = 8'(qi);
        r = 8'(ri);
      end
    end
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input bit noisy);
    logic [7:0] eq, er;
    logic eo, ez;
    int el, cyc;
    bit seen;
    ref_div(a, b, eq, er, eo, ez, el);
    go = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    go = 1'b0;
    chk("busy_start", busy, 1);
    seen = 0; cyc = 0;
    while (!seen && cyc < 30) begin
      if (noisy) begin
        go = 1'($urandom_range(0, 1));
        dividend = 16'($urandom);
        divisor = 8'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1;
    end
    go = 1'b0;
    chk($sformatf("lat %h/%h", a, b), cyc, el);
    chk($sformatf("quot %h/%h", a, b), quotient, eq);
    chk($sformatf("rem %h/%h", a, b), remainder, er);
    chk($sformatf("ovf %h/%h", a, b), ovf, eo);
    chk($sformatf("dz %h/%h", a, b), dz, ez);
    chk("busy_at_done", busy, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("quot_hold", quotient, eq);
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb, x;
    int e, nd;
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dz", dz, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h0AD6, 8'hDA, 1'b0);
    run_op(16'h0064, 8'h07, 1'b0);
    run_op(16'hFF9C, 8'h07, 1'b1);
    run_op(16'h0064, 8'hF9, 1'b0);
    run_op(16'h1234, 8'h00, 1'b0);
    run_op(16'h4000, 8'h01, 1'b1);
    run_op(16'hFF80, 8'h01, 1'b0);
    run_op(16'h0080, 8'h01, 1'b0);
    run_op(16'h8000, 8'h80, 1'b0);
    run_op(16'h7FFF, 8'h80, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rb = 8'($urandom);
      if ((i % 10) == 0) rb = 8'h00;
      case (i % 3)
        0: ra = 16'($urandom);
        1: begin x = 8'($urandom); ra = {{8{x[7]}}, x}; end
        default: begin
          ra = 16'($urandom_range(0, 16383));
          if ($urandom_range(0, 1) == 1) ra = -ra;
        end
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    // Abort in the 4th DIV cycle.
    go = 1'b1; dividend = 16'h0064; divisor = 8'h07;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quot", quotient, 0);
    chk("abort_rem", remainder, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_dz", dz, 0);
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    run_op(16'h0064, 8'h07, 1'b0);

    // go held high: three back-to-back operations.
    go = 1'b1; dividend = 16'h0AD6; divisor = 8'hDA;
    @(posedge clk); #1;
    e = 0; nd = 0;
    while (nd < 3 && e < 40) begin
      @(posedge clk); #1;
      e++;
      if (done) begin
        chk("b2b_lat", e, 10 + nd * 11);
        chk("b2b_quot", quotient, 8'hB7);
        nd++;
        if (nd == 3) go = 1'b0;
      end
    end
    go = 1'b0;
    chk("b2b_count", nd, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter DW, default 8, meaning divisor, quotient and remainder width; dividend width is 2*DW.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 go  input  1  start request, sampled only in IDLE.
REQ-005 dividend  input  2*DW  signed two's-complement dividend, sampled with go.
REQ-006 divisor  input  DW  signed two's-complement divisor, sampled with go.
REQ-007 busy  output  1  high from the cycle after go is accepted until the cycle done is high.
REQ-008 done  output  1  single-cycle pulse marking valid results.
REQ-009 quotient  output  DW  signed quotient, held until the next accepted go.
REQ-010 remainder  output  DW  signed remainder, held until the next accepted go.
REQ-011 ovf  output  1  result not representable, or divide by zero; held with the results.
REQ-012 dz  output  1  divisor was zero; held with the results.

Function
REQ-013 States SHALL be IDLE, LOAD, DIV, FIX; the encoding is private to the block.
REQ-014 IDLE: go=1 at a clock edge SHALL latch dividend and divisor and move to LOAD; go=0 stays in IDLE.
REQ-015 go SHALL be ignored in LOAD, DIV and FIX; inputs may change after acceptance without effect.
REQ-016 LOAD SHALL form magnitudes |dividend| (2*DW bits) and |divisor| (DW+1 bits internally), the result sign q_neg = dividend[MSB] xor divisor[MSB], and the remainder sign r_neg = dividend[MSB].
REQ-017 LOAD, divisor==0: set dz=1, ovf=1, go to FIX and skip DIV.
REQ-018 LOAD, upper DW bits of |dividend| >= |divisor|: set ovf=1, go to FIX and skip DIV.
REQ-019 LOAD, otherwise: go to DIV with the iteration counter at 0.
REQ-020 DIV SHALL perform one unsigned restoring step per cycle: shift partial remainder and quotient left 1; subtract |divisor| if the result is non-negative, setting the quotient LSB to 1.
REQ-021 DIV SHALL run exactly DW cycles; the counter wraps to 0 on exit to FIX.
REQ-022 FIX SHALL set ovf=1 if the magnitude quotient exceeds 2^(DW-1)-1 with q_neg=0, or exceeds 2^(DW-1) with q_neg=1.
REQ-023 FIX, no overflow: quotient = q_neg ? -mag : mag; remainder = r_neg ? -rem : rem (truncation toward zero).
REQ-024 FIX, ovf=1 (including dz): quotient=0 and remainder=0.
REQ-025 FIX SHALL register all outputs, pulse done for one cycle, and return to IDLE.
REQ-026 Latency from the go-accepting edge to done high: DW+2 cycles normally (10 for DW=8); 2 cycles on a LOAD-detected dz or ovf.
REQ-027 go held high continuously SHALL start a new operation on the first IDLE cycle after done.
REQ-028 ovf and dz SHALL clear on the next accepted go.

Reset
REQ-029 rst SHALL force state IDLE, counter 0, busy=0, done=0, quotient=0, remainder=0, ovf=0, dz=0 at the next edge.
REQ-030 rst mid-operation SHALL abort the operation with no done pulse; rst has priority over go.

Structure
REQ-031 A shared package SHALL hold the state enum typedef and the DW default constant.
REQ-032 One sub-module, twos_mag, SHALL provide the conditional two's-complement negate/absolute-value function; LOAD and FIX SHALL both instantiate it.

Verification
REQ-033 dividend=0x0AD6, divisor=0xDA -> quotient=0xB7, remainder=0x00, ovf=0, done 10 cycles after go.
REQ-034 0x0064/0x07 -> q=0x0E, r=0x02; 0xFF9C/0x07 -> q=0xF2, r=0xFE; 0x0064/0xF9 -> q=0xF2, r=0x02.
REQ-035 0x1234/0x00 -> dz=1, ovf=1, q=0x00, r=0x00, done 2 cycles after go; 0x4000/0x01 -> ovf=1, dz=0, done 2 cycles after go.
REQ-036 Signed boundary: 0xFF80/0x01 -> q=0x80, ovf=0; 0x0080/0x01 -> ovf=1, q=0x00 at the FIX check, done 10 cycles after go.
REQ-037 rst pulsed in the 4th DIV cycle -> no done pulse, all outputs 0, busy=0; a following go on 0x0064/0x07 completes normally.
REQ-038 go held high through three back-to-back operations -> one done per operation, each done 10 cycles after the go-accepting edge, and go pulses while busy are ignored.
